// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Multicycle ALU for the RISC-V datapath. Single-cycle ops (add/sub/logic,
//   shifts, compares) finish one cycle after Start. MUL/MULHU use an
//   iterative shift-add multiplier. DIVU/REMU use an iterative restoring
//   divider. Both iterative units take DATA_WIDTH steps.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   Start    in   launch; sampled only while Busy=0
//   Control  in   [3:0] operation select, captured with Start
//   A, B     in   [DATA_WIDTH-1:0] operands, captured with Start
//   Result   out  [DATA_WIDTH-1:0] registered result, changes only with Done
//   Zero     out  registered, Result==0
//   Busy     out  iterative operation in progress
//   Done     out  one-cycle pulse, Result/Zero valid from this cycle
//
// state  | meaning
// S_IDLE | waiting for Start
// S_MUL  | shift-add multiply, one step per cycle
// S_DIV  | restoring divide, one step per cycle
// S_DONE | Done pulse; a new Start may launch from here
module alu_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [3:0]            Control,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero,
  output logic                  Busy,
  output logic                  Done
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;        // MUL: multiplicand; DIV: dividend shifting into quotient
  logic [W-1:0]     b_q, b_d;        // MUL: multiplier shifting right; DIV: divisor
  logic [2*W-1:0]   acc_q, acc_d;    // MUL: product; DIV: remainder in low half
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic             zero_q, zero_d;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic [W-1:0]           single_res;
  logic [W:0]             mul_sum;
  logic [2*W-1:0]         mul_next;
  logic [W:0]             rem_sh;
  logic [W:0]             rem_diff;
  logic                   quo_bit;
  logic [W-1:0]           rem_next;
  logic [W-1:0]           quo_next;

  assign shamt = B[SHAMT_WIDTH-1:0];

  always_comb begin
    single_res = '0;
    case (Control)
      4'b0000: single_res = A + B;
      4'b0001: single_res = A - B;
      4'b0010: single_res = A & B;
      4'b0011: single_res = A | B;
      4'b0100: single_res = A ^ B;
      4'b0101: single_res = A << shamt;
      4'b0110: single_res = A >> shamt;
      4'b0111: single_res = $signed(A) >>> shamt;
      4'b1000: single_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1001: single_res = {{(W-1){1'b0}}, (A < B)};
      default: single_res = '0;
    endcase
  end

  // Right-shifting product: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole product right.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (b_q[0] ? a_q : {W{1'b0}})};
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Restoring step. With B==0 every step subtracts nothing, which naturally
  // gives an all-ones quotient and a remainder equal to A.
  assign rem_sh   = {acc_q[W-1:0], a_q[W-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign quo_bit  = (rem_sh >= {1'b0, b_q});
  assign rem_next = quo_bit ? rem_diff[W-1:0] : rem_sh[W-1:0];
  assign quo_next = {a_q[W-2:0], quo_bit};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          case (Control)
            4'b1010, 4'b1011: begin
              op_d    = Control;
              a_d     = A;
              b_d     = B;
              acc_d   = '0;
              cnt_d   = CNT_W'(W);
              state_d = S_MUL;
            end
            4'b1100, 4'b1101: begin
              op_d    = Control;
              a_d     = A;
              b_d     = B;
              acc_d   = '0;
              cnt_d   = CNT_W'(W);
              state_d = S_DIV;
            end
            default: begin
              result_d = single_res;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = op_q[0] ? mul_next[2*W-1:W] : mul_next[W-1:0];
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = {{W{1'b0}}, rem_next};
        a_d   = quo_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = op_q[0] ? rem_next : quo_next;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign Result = result_q;
  assign Zero   = zero_q;
  assign Busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign Done   = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle
//   Table of directed vectors, hand-written handshake/abort sequences and
//   randomized operations compared against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [3:0]  Control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        Zero;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .Start   (Start),
    .Control (Control),
    .A       (A),
    .B       (B),
    .Result  (Result),
    .Zero    (Zero),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat);
    vec_t v;
    v.ctrl = c; v.a = a; v.b = b; v.exp = e; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    p  = {32'd0, a} * {32'd0, b};
    sh = b[4:0];
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c);
    return (c >= 4'd10 && c <= 4'd13) ? 33 : 1;
  endfunction

  // Called one #1 after a clock edge. Returns in the Done cycle with Start=0.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, output logic [31:0] res, output logic z,
                        output int lat, output int busy_n);
    logic [31:0] prev;
    bit          hold_ok;
    prev    = Result;
    hold_ok = 1'b1;
    Start = 1'b1; Control = c; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; Control = 4'($urandom); A = $urandom; B = $urandom;
    lat = 0; busy_n = 0;
    while (lat < 100) begin
      lat++;
      if (Done) break;
      if (Busy) busy_n++;
      if (Result !== prev) hold_ok = 1'b0;
      if (disturb) begin
        Start = 1'b1; Control = 4'($urandom); A = $urandom; B = $urandom;
      end
      @(posedge clk); #1;
      Start = 1'b0;
    end
    res = Result;
    z   = Zero;
    check("result_hold_until_done", 64'(hold_ok), 64'd1);
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    int          busy_n;
    int          stray;
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;

    add_vec(4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    add_vec(4'b0001, 32'd3,         32'd5,         32'hFFFF_FFFE, 1);
    add_vec(4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    add_vec(4'b0011, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1);
    add_vec(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    add_vec(4'b0101, 32'h1,         32'h3F,        32'h8000_0000, 1);
    add_vec(4'b0110, 32'h8000_0000, 32'h4,         32'h0800_0000, 1);
    add_vec(4'b0111, 32'h8000_0000, 32'h24,        32'hF800_0000, 1);
    add_vec(4'b1000, 32'hFFFF_FFFF, 32'h1,         32'h1,         1);
    add_vec(4'b1001, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    add_vec(4'b1110, 32'h1234,      32'h5678,      32'h0,         1);
    add_vec(4'b1111, 32'h1234,      32'h5678,      32'h0,         1);
    add_vec(4'b1010, 32'h0001_2345, 32'h0000_6789, 32'h75CC_A2ED, 33);
    add_vec(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    add_vec(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    add_vec(4'b1010, 32'hDEAD_BEEF, 32'h0,         32'h0,         33);
    add_vec(4'b1100, 32'd100,       32'd7,         32'd14,        33);
    add_vec(4'b1101, 32'd100,       32'd7,         32'd2,         33);
    add_vec(4'b1100, 32'd5,         32'd0,         32'hFFFF_FFFF, 33);
    add_vec(4'b1101, 32'd5,         32'd0,         32'd5,         33);

    // Reset held with Start asserted must not launch anything.
    rst = 1'b1; Start = 1'b1; Control = 4'b0000; A = 32'd5; B = 32'd6;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 64'(Result), 64'd0);
    check("reset_zero",   64'(Zero),   64'd1);
    check("reset_busy",   64'(Busy),   64'd0);
    check("reset_done",   64'(Done),   64'd0);
    rst = 1'b0; Start = 1'b0;
    @(posedge clk); #1;
    check("post_reset_no_done",   64'(Done),   64'd0);
    check("post_reset_no_result", 64'(Result), 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, 1'b0, res, z, lat, busy_n);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_zero", i),   64'(z),   64'(vecs[i].exp == 0));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(vecs[i].lat - 1));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_one_cycle", i), 64'(Done), 64'd0);
    end

    // Start re-pulsed with garbage while the multiplier is busy.
    run_op(4'b1010, 32'h0001_2345, 32'h0000_6789, 1'b1, res, z, lat, busy_n);
    check("busy_ignore_result",  64'(res), 64'h75CC_A2ED);
    check("busy_ignore_latency", 64'(lat), 64'd33);

    // Back-to-back: new ADD launched in the Done cycle of a MUL.
    run_op(4'b1010, 32'd7, 32'd6, 1'b0, res, z, lat, busy_n);
    check("b2b_first_result", 64'(res), 64'd42);
    Start = 1'b1; Control = 4'b0000; A = 32'd2; B = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    check("b2b_second_done",   64'(Done),   64'd1);
    check("b2b_second_result", 64'(Result), 64'd5);
    check("b2b_second_zero",   64'(Zero),   64'd0);
    @(posedge clk); #1;
    check("b2b_done_drops", 64'(Done), 64'd0);

    // Abort a DIVU at iteration 10.
    Start = 1'b1; Control = 4'b1100; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", 64'(Busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy",   64'(Busy),   64'd0);
    check("abort_done",   64'(Done),   64'd0);
    check("abort_result", 64'(Result), 64'd0);
    check("abort_zero",   64'(Zero),   64'd1);
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done) stray++;
    end
    check("abort_no_late_done", 64'(stray), 64'd0);
    run_op(4'b0000, 32'd9, 32'd1, 1'b0, res, z, lat, busy_n);
    check("after_abort_result",  64'(res), 64'd10);
    check("after_abort_latency", 64'(lat), 64'd1);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rc, ra, rb, 1'b0, res, z, lat, busy_n);
      check($sformatf("rand%0d_op%0d_result", n, rc), 64'(res), 64'(model(rc, ra, rb)));
      check($sformatf("rand%0d_zero", n), 64'(z), 64'(model(rc, ra, rb) == 0));
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'(model_lat(rc)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
